regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU (A) vs load (B) ports.
// Rotating priority, x0 bypass, one registered write strobe.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        Reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_address,
  output logic [31:0] write_data,
  output logic        last_grant_b,
  output logic [7:0]  conflict_count
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e state;
  pri_e state_nxt;

  logic a_real;
  logic b_real;
  logic both_real;
  logic grant_a;
  logic grant_b;

  // Real requests target a register other than x0.
  always_comb begin
    a_real    = a_valid && (a_addr != 5'd0);
    b_real    = b_valid && (b_addr != 5'd0);
    both_real = a_real && b_real;
  end

  // Grant selection and next priority; x0 requests are absorbed freely.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    if (!Reset) begin
      grant_a = a_real && (!b_real || state == PRI_A);
      grant_b = b_real && (!a_real || state == PRI_B);
      a_ready = grant_a || (a_valid && a_addr == 5'd0);
      b_ready = grant_b || (b_valid && b_addr == 5'd0);
    end
    unique case (1'b1)
      grant_a: state_nxt = PRI_B;
      grant_b: state_nxt = PRI_A;
      default: state_nxt = state;
    endcase
  end

  // Priority state register.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= PRI_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Output write register; address/data/grant hold when idle.
  always_ff @(posedge clock) begin
    if (Reset) begin
      reg_write_enable  <= 1'b0;
      reg_write_address <= 5'd0;
      write_data        <= 32'd0;
      last_grant_b      <= 1'b0;
    end else if (grant_a) begin
      reg_write_enable  <= 1'b1;
      reg_write_address <= a_addr;
      write_data        <= a_data;
      last_grant_b      <= 1'b0;
    end else if (grant_b) begin
      reg_write_enable  <= 1'b1;
      reg_write_address <= b_addr;
      write_data        <= b_data;
      last_grant_b      <= 1'b1;
    end else begin
      reg_write_enable  <= 1'b0;
    end
  end

  // Saturating count of cycles with two competing real requests.
  always_ff @(posedge clock) begin
    if (Reset) begin
      conflict_count <= 8'd0;
    end else if (both_real && conflict_count != 8'hff) begin
      conflict_count <= conflict_count + 8'd1;
    end
  end

endmodule
